// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake to a variable-latency memory, pipeline stall until done.
// Optional MEM_TIMEOUT_EN: abort a BUSY access after MAX_WAIT cycles and raise the sticky err_o flag.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              access;
  logic              req_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic [DATA_W-1:0] rdata_nx;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       err_q, err_nx;
`endif

  assign access  = MemRead_i | MemWrite_i;
  assign stall_o = ((state == IDLE) && access) || (state == BUSY);

  always_comb begin
    state_nx = state;
    req_nx   = mem_req_o;
    we_nx    = mem_we_o;
    addr_nx  = mem_addr_o;
    wdata_nx = mem_wdata_o;
    rdata_nx = rdata_o;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
    err_nx      = err_q;
`endif
    case (state)
      IDLE: begin
        if (access) begin
          addr_nx  = addr_i;
          wdata_nx = wdata_i;
          we_nx    = MemWrite_i;
          req_nx   = 1'b1;
          state_nx = BUSY;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_nx = '0;
`endif
        end
      end
      BUSY: begin
        // An ack wins over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          req_nx = 1'b0;
          if (!mem_we_o) begin
            rdata_nx = mem_rdata_i;
          end
          state_nx = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          req_nx = 1'b0;
          if (!mem_we_o) begin
            rdata_nx = '0;
          end
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
`endif
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      state       <= state_nx;
      mem_req_o   <= req_nx;
      mem_we_o    <= we_nx;
      mem_addr_o  <= addr_nx;
      mem_wdata_o <= wdata_nx;
      rdata_o     <= rdata_nx;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nx;
      err_q    <= err_nx;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with hand-written multi-cycle sequences.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One record per clock cycle; expected values are the outputs seen during that cycle.
  typedef struct {
    logic        rst, rd, wr;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] mrdata;
    logic        chk;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic ack, input logic [31:0] mrdata, input logic chk,
                     input logic e_stall, input logic e_req, input logic e_we,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ack = ack; v.mrdata = mrdata; v.chk = chk;
    v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_err = e_err;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ack, input logic [31:0] mrdata);
    @(negedge clk_i);
    rst_i = 1'b0; MemRead_i = rd; MemWrite_i = wr; addr_i = addr; wdata_i = wdata;
    mem_ack_i = ack; mem_rdata_i = mrdata;
    #1;
  endtask

  initial begin
    int busy_cycles;
    logic done_seen;

    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    // rst rd wr addr wdata ack mrdata | chk | stall req we addr wdata rdata err
    add(1,0,0,0,0,0,0,                           0, 0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,                           1, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,                           1, 0,0,0,0,0,0,0);
    // load, ack in first BUSY cycle
    add(0,1,0,'h100,'hAAAA,0,0,                  1, 1,0,0,0,0,0,0);
    add(0,1,0,'h100,'hAAAA,1,'hDEADBEEF,         1, 1,1,0,'h100,'hAAAA,0,0);
    add(0,1,0,'h100,'hAAAA,0,0,                  1, 0,0,0,'h100,'hAAAA,'hDEADBEEF,0);
    add(0,0,0,0,0,0,0,                           1, 0,0,0,'h100,'hAAAA,'hDEADBEEF,0);
    // store, 3 wait cycles
    add(0,0,1,'h20,'h1234,0,0,                   1, 1,0,0,'h100,'hAAAA,'hDEADBEEF,0);
    add(0,0,1,'h20,'h1234,0,'h0BAD0BAD,          1, 1,1,1,'h20,'h1234,'hDEADBEEF,0);
    add(0,0,1,'h20,'h1234,0,'h0BAD0BAD,          1, 1,1,1,'h20,'h1234,'hDEADBEEF,0);
    add(0,0,1,'h20,'h1234,0,'h0BAD0BAD,          1, 1,1,1,'h20,'h1234,'hDEADBEEF,0);
    add(0,0,1,'h20,'h1234,1,'h0BAD0BAD,          1, 1,1,1,'h20,'h1234,'hDEADBEEF,0);
    add(0,0,1,'h20,'h1234,0,0,                   1, 0,0,1,'h20,'h1234,'hDEADBEEF,0);
    add(0,0,0,0,0,0,0,                           1, 0,0,1,'h20,'h1234,'hDEADBEEF,0);
    // back-to-back load then store, stray ack in DONE and IDLE
    add(0,1,0,'h44,0,0,0,                        1, 1,0,1,'h20,'h1234,'hDEADBEEF,0);
    add(0,1,0,'h44,0,1,'hCAFEF00D,               1, 1,1,0,'h44,0,'hDEADBEEF,0);
    add(0,1,0,'h44,0,1,'h11111111,               1, 0,0,0,'h44,0,'hCAFEF00D,0);
    add(0,0,1,'h48,'h5678,0,0,                   1, 1,0,0,'h44,0,'hCAFEF00D,0);
    add(0,0,1,'h48,'h5678,1,'h22222222,          1, 1,1,1,'h48,'h5678,'hCAFEF00D,0);
    add(0,0,1,'h48,'h5678,0,0,                   1, 0,0,1,'h48,'h5678,'hCAFEF00D,0);
    add(0,0,0,0,0,1,'h33333333,                  1, 0,0,1,'h48,'h5678,'hCAFEF00D,0);
    add(0,0,0,0,0,0,0,                           1, 0,0,1,'h48,'h5678,'hCAFEF00D,0);
    // read and write together count as a write
    add(0,1,1,'h60,'h9,0,0,                      1, 1,0,1,'h48,'h5678,'hCAFEF00D,0);
    add(0,1,1,'h60,'h9,1,'h44444444,             1, 1,1,1,'h60,'h9,'hCAFEF00D,0);
    add(0,0,0,0,0,0,0,                           1, 0,0,1,'h60,'h9,'hCAFEF00D,0);
    // reset in BUSY, late ack afterwards
    add(0,1,0,'h80,0,0,0,                        1, 1,0,1,'h60,'h9,'hCAFEF00D,0);
    add(0,1,0,'h80,0,0,0,                        1, 1,1,0,'h80,0,'hCAFEF00D,0);
    add(1,0,0,0,0,0,0,                           1, 1,1,0,'h80,0,'hCAFEF00D,0);
    add(0,0,0,0,0,1,'h55555555,                  1, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,                           1, 0,0,0,0,0,0,0);

    foreach (vq[i]) begin
      @(negedge clk_i);
      rst_i = vq[i].rst; MemRead_i = vq[i].rd; MemWrite_i = vq[i].wr;
      addr_i = vq[i].addr; wdata_i = vq[i].wdata;
      mem_ack_i = vq[i].ack; mem_rdata_i = vq[i].mrdata;
      #1;
      if (vq[i].chk) begin
        check($sformatf("v%0d stall", i), 32'(stall_o),   32'(vq[i].e_stall));
        check($sformatf("v%0d req", i),   32'(mem_req_o), 32'(vq[i].e_req));
        check($sformatf("v%0d we", i),    32'(mem_we_o),  32'(vq[i].e_we));
        check($sformatf("v%0d addr", i),  mem_addr_o,     vq[i].e_addr);
        check($sformatf("v%0d wdata", i), mem_wdata_o,    vq[i].e_wdata);
        check($sformatf("v%0d rdata", i), rdata_o,        vq[i].e_rdata);
        check($sformatf("v%0d err", i),   32'(err_o),     32'(vq[i].e_err));
      end
    end

`ifdef MEM_TIMEOUT_EN
    // Normal load first so rdata_o is non-zero before the timeout clears it.
    drive(1, 0, 'h300, 0, 0, 0);
    check("to_pre_stall", 32'(stall_o), 32'd1);
    drive(1, 0, 'h300, 0, 1, 'h77);
    drive(1, 0, 'h300, 0, 0, 0);
    check("to_pre_rdata", rdata_o, 32'h77);
    drive(0, 0, 0, 0, 0, 0);

    drive(1, 0, 'h304, 0, 0, 0);
    check("to_idle_stall", 32'(stall_o), 32'd1);
    busy_cycles = 0;
    done_seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      #1;
      if (!stall_o) begin
        done_seen = 1'b1;
        break;
      end
      busy_cycles++;
    end
    check("to_done_reached", 32'(done_seen), 32'd1);
    check("to_busy_cycles", 32'(busy_cycles), 32'(MAX_WAIT));
    check("to_rdata", rdata_o, 32'h0);
    check("to_err", 32'(err_o), 32'd1);
    check("to_req", 32'(mem_req_o), 32'd0);

    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 'h308, 'hABCD, 0, 0);
    drive(0, 1, 'h308, 'hABCD, 1, 0);
    drive(0, 1, 'h308, 'hABCD, 0, 0);
    check("to_sticky_stall", 32'(stall_o), 32'd0);
    check("to_sticky_err", 32'(err_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    check("to_sticky_err_idle", 32'(err_o), 32'd1);
`else
    // Without the timeout, BUSY must wait indefinitely for the ack.
    drive(1, 0, 'h200, 0, 0, 0);
    check("wait_idle_stall", 32'(stall_o), 32'd1);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      #1;
      if (stall_o && mem_req_o) busy_cycles++;
    end
    check("wait_busy_cycles", 32'(busy_cycles), 32'd40);
    check("wait_err", 32'(err_o), 32'd0);
    drive(1, 0, 'h200, 0, 1, 'h600DF00D);
    drive(1, 0, 'h200, 0, 0, 0);
    check("wait_done_stall", 32'(stall_o), 32'd0);
    check("wait_done_rdata", rdata_o, 32'h600DF00D);
    check("wait_done_err", 32'(err_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    check("wait_idle_req", 32'(mem_req_o), 32'd0);
    done_seen = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle data-memory sequencer for the MEM stage of the CPU datapath.
- Takes the MemRead/MemWrite controls and the address/store data from the MEM stage.
- Drives a req/ack handshake to a variable-latency data memory.
- Holds stall_o high to freeze the pipeline until the access completes, then presents load data for the writeback path.

Parameters:
- ADDR_W, 32, width of address bus.
- DATA_W, 32, width of data buses.
- MAX_WAIT, 16, cycles in BUSY before timeout abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- MemRead_i  in  1  load request from control path.
- MemWrite_i  in  1  store request from control path.
- addr_i  in  ADDR_W  effective address from ALU.
- wdata_i  in  DATA_W  store data.
- rdata_o  out  DATA_W  registered load data; valid in DONE.
- stall_o  out  1  pipeline freeze request.
- mem_req_o  out  1  memory request strobe (registered).
- mem_we_o  out  1  1 = write, 0 = read (registered).
- mem_addr_o  out  ADDR_W  latched address.
- mem_wdata_o  out  DATA_W  latched store data.
- mem_ack_i  in  1  memory completion, 1-cycle pulse.
- mem_rdata_i  in  DATA_W  read data; valid while mem_ack_i=1.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset, synchronous, rst_i=1 at a clock edge:
  - State goes to IDLE; this includes reset mid-access.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0.
  - stall_o=0 on the following cycle.
  - A memory ack arriving after reset is ignored.
- Access detection: access = MemRead_i | MemWrite_i. If both are 1, the access is a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access=1: latch addr_i → mem_addr_o, wdata_i → mem_wdata_o, MemWrite_i → mem_we_o; set mem_req_o=1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mem_req_o stays 1. mem_addr_o, mem_we_o and mem_wdata_o are held stable.
  - On mem_ack_i=1: mem_req_o←0; for a read, rdata_o←mem_rdata_i (a write leaves rdata_o unchanged); go to DONE.
- DONE:
  - Lasts exactly 1 cycle, then goes to IDLE.
  - The pipeline advances at the end of this cycle.
  - Inputs are not sampled in DONE; the next instruction's access is detected in the following IDLE cycle.
- stall_o is combinational: (IDLE & access) | BUSY. It is 0 in DONE and in IDLE with no access.
- Latency: an access detected in cycle N with ack in the first BUSY cycle (N+1) gives DONE at N+2. Minimum is 2 stall cycles; in general stall cycles = 1 + BUSY cycles.
- mem_ack_i seen in IDLE or DONE is ignored; it causes no state change.
- rdata_o holds its value until the next completed read or reset.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches MAX_WAIT-1 without ack: mem_req_o←0, rdata_o←0 (for a read), err_o←1, go to DONE.
  - err_o is sticky until reset.
  - An ack in the same cycle as the timeout takes priority: it is a normal completion and err_o is not set.
- Not defined: BUSY waits indefinitely, no counter logic is built, and err_o is tied to 0.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, no access → stall_o=0, mem_req_o=0, rdata_o=0, err_o=0.
- Load with 0-wait ack: MemRead_i=1, addr_i=0x100, ack in the first BUSY cycle with mem_rdata_i=0xDEADBEEF → stall_o high for exactly 2 cycles, mem_we_o=0, mem_addr_o=0x100, rdata_o=0xDEADBEEF in DONE.
- Store with 3-cycle wait: MemWrite_i=1, addr_i=0x20, wdata_i=0x1234 → mem_req_o high for 4 cycles with mem_we_o=1 and mem_wdata_o=0x1234 stable; rdata_o unchanged; stall_o 5 cycles.
- Back-to-back: load immediately followed by a store → DONE for the load, then IDLE detects the store; exactly one request per instruction; stray ack in DONE ignored.
- Reset mid-access: rst_i=1 during BUSY → next cycle IDLE, mem_req_o=0, stall_o=0; a later ack causes no change.
- MEM_TIMEOUT_EN with MAX_WAIT=16: load with no ack → after 16 BUSY cycles DONE with rdata_o=0 and err_o=1; err_o stays 1 through a subsequent normal access.
